// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sample loader slice.
package fft_pkg;
  localparam int FFT_DATA_W = 16;
  localparam int FFT_N_PTS  = 4;

  typedef logic [FFT_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    LD_FILL,
    LD_ISSUE,
    LD_RELEASE
  } loader_state_e;
endpackage

// File: rtl/fft_sample_loader_if.sv
// Sample stream plus the level start/done link to the FFT core.
// Handshake: a sample moves on a rising clk edge when in_valid && in_ready; fft_start/fft_done are levels.
interface fft_sample_loader_if #(parameter int DATA_W = fft_pkg::FFT_DATA_W);
  import fft_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] fft_samples [0:FFT_N_PTS-1];
  logic              fft_start;
  logic              fft_done;

  modport master (
    output in_data, in_valid, fft_done,
    input  in_ready, fft_samples, fft_start
  );

  modport slave (
    input  in_data, in_valid, fft_done,
    output in_ready, fft_samples, fft_start
  );
endinterface

// File: rtl/fft_frame_bank.sv
// One frame of sample registers, written one slot at a time and read as a whole frame.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_frame [0:FFT_N_PTS-1]
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FFT_N_PTS; i++) rd_frame[i] <= '0;
    end else if (wr_en) begin
      rd_frame[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/fft_sample_loader.sv
// Packs a serial sample stream into 4-sample frames and runs the FFT core start/done handshake.
// Define FFT_LOADER_DBUF_EN for ping-pong banks so the next frame fills while the core runs.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int DATA_W  = FFT_DATA_W,
  parameter int N_PTS   = FFT_N_PTS,
  parameter int FFT_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  fft_sample_loader_if.slave ld,
  output logic [15:0]        frame_cnt,
  output logic               busy,
  output loader_state_e      state_dbg
);
  localparam int LAT_W = $clog2(FFT_LAT + 1);

  if (N_PTS != 4) begin : g_bad_n_pts
    $error("fft_sample_loader: N_PTS must be 4");
  end

  loader_state_e     state, state_nx;
  logic [1:0]        fill_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [15:0]       frame_cnt_q;
  logic              fft_start_q;
  logic              xfer, fill_last, lat_done, swap;
  logic [DATA_W-1:0] frame0 [0:FFT_N_PTS-1];

  assign xfer      = ld.in_valid && ld.in_ready;
  assign fill_last = xfer && (fill_cnt == 2'd3);
  assign lat_done  = (lat_cnt == LAT_W'(FFT_LAT));

`ifdef FFT_LOADER_DBUF_EN
  logic              sel, back_full, wr_bank;
  logic [DATA_W-1:0] frame1 [0:FFT_N_PTS-1];

  // On a swap the outgoing front bank becomes the back bank, so a transfer in that cycle targets it.
  assign swap        = (state == LD_RELEASE) && (back_full || fill_last);
  assign wr_bank     = (state == LD_RELEASE && back_full) ? sel : ~sel;
  assign ld.in_ready = !back_full || (state == LD_RELEASE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= 1'b0;
      back_full <= 1'b0;
    end else begin
      if (swap || (state == LD_FILL && fill_last)) sel <= ~sel;
      back_full <= (state == LD_ISSUE) && (back_full || fill_last);
    end
  end

  fft_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk(clk), .reset(reset), .wr_en(xfer && !wr_bank), .wr_idx(fill_cnt),
    .wr_data(ld.in_data), .rd_frame(frame0)
  );
  fft_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk(clk), .reset(reset), .wr_en(xfer && wr_bank), .wr_idx(fill_cnt),
    .wr_data(ld.in_data), .rd_frame(frame1)
  );

  always_comb begin
    for (int i = 0; i < FFT_N_PTS; i++) ld.fft_samples[i] = sel ? frame1[i] : frame0[i];
  end
`else
  assign swap        = 1'b0;
  assign ld.in_ready = (state == LD_FILL);

  fft_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk(clk), .reset(reset), .wr_en(xfer), .wr_idx(fill_cnt),
    .wr_data(ld.in_data), .rd_frame(frame0)
  );

  always_comb begin
    for (int i = 0; i < FFT_N_PTS; i++) ld.fft_samples[i] = frame0[i];
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      LD_FILL:    if (fill_last) state_nx = LD_ISSUE;
      // A done seen before lat_cnt saturates is left over from the previous frame.
      LD_ISSUE:   if (lat_done && ld.fft_done) state_nx = LD_RELEASE;
      LD_RELEASE: state_nx = swap ? LD_ISSUE : LD_FILL;
      default:    state_nx = LD_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LD_FILL;
      fill_cnt    <= 2'd0;
      lat_cnt     <= '0;
      fft_start_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state       <= state_nx;
      fft_start_q <= (state_nx == LD_ISSUE);
      if (xfer) fill_cnt <= fill_cnt + 2'd1;
      if (state == LD_ISSUE) begin
        if (!lat_done) lat_cnt <= lat_cnt + LAT_W'(1);
      end else begin
        lat_cnt <= '0;
      end
      if (state == LD_ISSUE && state_nx == LD_RELEASE) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign ld.fft_start = fft_start_q;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = (state != LD_FILL) || (fill_cnt != 2'd0);
  assign state_dbg    = state;
endmodule
